// File: rtl/mpp_fetch_pkg.sv
// Shared types for the mpp instruction fetch unit: address/data widths,
// fetch FSM states and the prefetch queue entry layout.
package mpp_fetch_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch queue of {pc, byte} entries; flush beats push and pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import mpp_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  fetch_entry_t               pushData_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output fetch_entry_t               head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] rdPtr_q;
  logic [PtrW-1:0] wrPtr_q;
  logic [CntW-1:0] count_q;
  logic            doPush;
  logic            doPop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];

  // A push at full is only legal when the head leaves in the same cycle.
  assign doPush = push_i && (!full_o || pop_i);
  assign doPop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PtrW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PtrW'(1);
      count_q <= count_q + CntW'(doPush) - CntW'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !flush_i && !reset) mem_q[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// ROM-side fetch FSM plus prefetch queue for the mpp core.
// Optional ROM timeout watchdog enabled with `define FETCH_TIMEOUT_EN.
module instr_fetch_unit
  import mpp_fetch_pkg::*;
#(
  parameter int          DEPTH          = 4,
  parameter logic [15:0] RESET_PC       = 16'h0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] rom_addr,
  output logic        rom_cs,
  output logic        rom_rd,
  input  logic [7:0]  rom_data,
  input  logic        rom_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_addr,
  input  logic        halt,
  output logic [7:0]  instruction,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fetch_err
);

  localparam int CntW = $clog2(DEPTH) + 1;

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] fetchPc_q;
  logic [ADDR_W-1:0] romAddr_q;
  logic [ADDR_W-1:0] fetchPcInc;
  logic              fifoPush;
  logic              fifoPop;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [CntW-1:0]   fifoCount;
  fetch_entry_t      pushEntry;
  fetch_entry_t      headEntry;
  logic              spaceAfterPush;
  logic              canIssue;
  logic              timeoutHit;
  logic              errBlock;

  assign fetchPcInc = fetchPc_q + 16'd1;
  assign pushEntry  = '{pc: fetchPc_q, data: rom_data};

  // Redirect squashes both the completing byte and any pop this cycle.
  assign fifoPush = (state_q == FETCH) && rom_ready && !redirect;
  assign fifoPop  = instr_valid && instr_ready && !redirect;

  assign spaceAfterPush = (fifoCount < CntW'(DEPTH - 1)) || fifoPop;
  assign canIssue       = !halt && (fifoCount < CntW'(DEPTH)) && !errBlock;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (fifoPush),
    .pushData_i(pushEntry),
    .pop_i     (fifoPop),
    .flush_i   (redirect),
    .head_o    (headEntry),
    .full_o    (fifoFull),
    .empty_o   (fifoEmpty),
    .count_o   (fifoCount)
  );

  assign rom_cs      = (state_q != IDLE);
  assign rom_rd      = rom_cs;
  assign rom_addr    = romAddr_q;
  assign instr_valid = !fifoEmpty;
  assign instruction = instr_valid ? headEntry.data : 8'h00;
  assign instr_pc    = instr_valid ? headEntry.pc   : 16'h0000;

`ifdef FETCH_TIMEOUT_EN
  localparam int TimerW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TimerW-1:0] timer_q;
  logic              fetchErr_q;

  assign timeoutHit = (state_q != IDLE) && !rom_ready &&
                      (timer_q == TimerW'(TIMEOUT_CYCLES - 1));
  assign errBlock   = fetchErr_q;
  assign fetch_err  = fetchErr_q;

  // Counts consecutive wait cycles on an outstanding request; error is sticky.
  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      timer_q    <= '0;
      fetchErr_q <= 1'b0;
    end else if (state_q == IDLE || rom_ready) begin
      timer_q <= '0;
    end else if (timeoutHit) begin
      timer_q    <= '0;
      fetchErr_q <= 1'b1;
    end else begin
      timer_q <= timer_q + TimerW'(1);
    end
  end
`else
  assign timeoutHit = 1'b0;
  assign errBlock   = 1'b0;
  assign fetch_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      fetchPc_q <= RESET_PC;
      romAddr_q <= RESET_PC;
    end else if (redirect) begin
      fetchPc_q <= redirect_addr;
      // A still-pending request must finish on the bus before we move on.
      state_q   <= (state_q != IDLE && !rom_ready) ? DISCARD : IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (canIssue) begin
            state_q   <= FETCH;
            romAddr_q <= fetchPc_q;
          end
        end
        FETCH: begin
          if (rom_ready) begin
            fetchPc_q <= fetchPcInc;
            if (spaceAfterPush && !halt) begin
              romAddr_q <= fetchPcInc;
            end else begin
              state_q <= IDLE;
            end
          end else if (timeoutHit) begin
            state_q <= IDLE;
          end
        end
        DISCARD: begin
          if (rom_ready || timeoutHit) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; ROM model returns the
// low address byte. Timeout scenario depends on `define FETCH_TIMEOUT_EN.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] romAddr;
  logic        romCs;
  logic        romRd;
  logic [7:0]  romData;
  logic        romReady;
  logic        redirect;
  logic [15:0] redirectAddr;
  logic        halt;
  logic [7:0]  instruction;
  logic [15:0] instrPc;
  logic        instrValid;
  logic        instrReady;
  logic        fetchErr;

  int total = 0;
  int bad   = 0;

  logic [15:0] readQ[$];
  logic [23:0] popQ[$];

  always #5 clk = ~clk;

  assign romData = romAddr[7:0];

  instr_fetch_unit #(
    .DEPTH         (4),
    .RESET_PC      (16'h0000),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rom_addr     (romAddr),
    .rom_cs       (romCs),
    .rom_rd       (romRd),
    .rom_data     (romData),
    .rom_ready    (romReady),
    .redirect     (redirect),
    .redirect_addr(redirectAddr),
    .halt         (halt),
    .instruction  (instruction),
    .instr_pc     (instrPc),
    .instr_valid  (instrValid),
    .instr_ready  (instrReady),
    .fetch_err    (fetchErr)
  );

  // Record completed ROM reads and accepted instructions between edges.
  always @(negedge clk) begin
    if (!reset && !redirect && romCs && romReady) readQ.push_back(romAddr);
    if (!reset && !redirect && instrValid && instrReady) popQ.push_back({instrPc, instruction});
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic rdy, input logic iRdy,
                               input logic redir, input logic [15:0] rAddr, input logic hlt);
    reset        = rst;
    romReady     = rdy;
    instrReady   = iRdy;
    redirect     = redir;
    redirectAddr = rAddr;
    halt         = hlt;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset state
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    tick(2);
    checkOutput("rstRomCs", 32'(romCs), 32'h0);
    checkOutput("rstRomRd", 32'(romRd), 32'h0);
    checkOutput("rstRomAddr", 32'(romAddr), 32'h0000);
    checkOutput("rstValid", 32'(instrValid), 32'h0);
    checkOutput("rstInstr", 32'(instruction), 32'h00);
    checkOutput("rstPc", 32'(instrPc), 32'h0000);
    checkOutput("rstErr", 32'(fetchErr), 32'h0);

    // Streaming from reset, one byte per cycle
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    tick(1);
    checkOutput("strmCs1", 32'(romCs), 32'h1);
    checkOutput("strmAddr1", 32'(romAddr), 32'h0000);
    checkOutput("strmValid1", 32'(instrValid), 32'h0);
    tick(1);
    checkOutput("strmValid2", 32'(instrValid), 32'h1);
    checkOutput("strmInstr2", 32'(instruction), 32'h00);
    checkOutput("strmPc2", 32'(instrPc), 32'h0000);
    checkOutput("strmAddr2", 32'(romAddr), 32'h0001);
    tick(1);
    checkOutput("strmInstr3", 32'(instruction), 32'h01);
    checkOutput("strmPc3", 32'(instrPc), 32'h0001);
    tick(3);
    checkOutput("strmInstr6", 32'(instruction), 32'h04);
    checkOutput("strmPc6", 32'(instrPc), 32'h0004);

    // Backpressure: queue fills with exactly four reads then stops
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    readQ.delete();
    tick(10);
    checkOutput("fullReads", 32'(readQ.size()), 32'd4);
    for (int i = 0; i < 4 && i < readQ.size(); i++)
      checkOutput($sformatf("fullReadAddr%0d", i), 32'(readQ[i]), 32'(i));
    checkOutput("fullCs", 32'(romCs), 32'h0);
    checkOutput("fullValid", 32'(instrValid), 32'h1);
    checkOutput("fullHead", 32'(instruction), 32'h00);
    popQ.delete();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    tick(12);
    checkOutput("resumeCount", 32'(popQ.size() >= 8), 32'h1);
    for (int i = 0; i < 8 && i < popQ.size(); i++)
      checkOutput($sformatf("resumePop%0d", i), 32'(popQ[i]), {8'h00, 16'(i), 8'(i)});

    // Slow ROM: request held stable until ready
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick(1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput($sformatf("waitCs%0d", i), 32'(romCs), 32'h1);
      checkOutput($sformatf("waitAddr%0d", i), 32'(romAddr), 32'h0000);
      checkOutput($sformatf("waitValid%0d", i), 32'(instrValid), 32'h0);
    end
    romReady = 1'b1;
    tick(1);
    romReady = 1'b0;
    checkOutput("slowValid", 32'(instrValid), 32'h1);
    checkOutput("slowHead", 32'({instrPc, instruction}), 32'h000000);
    checkOutput("slowNextAddr", 32'(romAddr), 32'h0001);
    tick(2);
    checkOutput("slowHeadHeld", 32'({instrPc, instruction}), 32'h000000);

    // Redirect while a request is pending
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0);
    tick(1);
    checkOutput("redirFlush", 32'(instrValid), 32'h0);
    checkOutput("redirHoldCs", 32'(romCs), 32'h1);
    checkOutput("redirHoldAddr", 32'(romAddr), 32'h0001);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick(1);
    checkOutput("discardCs", 32'(romCs), 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    tick(1);
    checkOutput("discardDoneCs", 32'(romCs), 32'h0);
    checkOutput("discardDropped", 32'(instrValid), 32'h0);
    tick(1);
    checkOutput("redirAddr", 32'(romAddr), 32'h1234);
    checkOutput("redirCs", 32'(romCs), 32'h1);
    tick(1);
    checkOutput("redirValid", 32'(instrValid), 32'h1);
    checkOutput("redirPc", 32'(instrPc), 32'h1234);
    checkOutput("redirInstr", 32'(instruction), 32'h34);

    // Halt lets the outstanding read finish, then stops requesting
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
    tick(1);
    checkOutput("haltCs1", 32'(romCs), 32'h0);
    tick(1);
    checkOutput("haltCs2", 32'(romCs), 32'h0);

    // Address wrap after redirect to FFFE
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0);
    tick(1);
    popQ.delete();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    tick(6);
    checkOutput("wrapCount", 32'(popQ.size() >= 3), 32'h1);
    if (popQ.size() >= 3) begin
      checkOutput("wrapPop0", 32'(popQ[0]), 32'hFFFEFE);
      checkOutput("wrapPop1", 32'(popQ[1]), 32'hFFFFFF);
      checkOutput("wrapPop2", 32'(popQ[2]), 32'h000000);
    end

    // ROM never answers
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    tick(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    tick(1);
`ifdef FETCH_TIMEOUT_EN
    tick(15);
    checkOutput("toBeforeCs", 32'(romCs), 32'h1);
    checkOutput("toBeforeErr", 32'(fetchErr), 32'h0);
    tick(1);
    checkOutput("toErr", 32'(fetchErr), 32'h1);
    checkOutput("toCs", 32'(romCs), 32'h0);
    tick(3);
    checkOutput("toStayIdle", 32'(romCs), 32'h0);
    checkOutput("toSticky", 32'(fetchErr), 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h0010, 1'b0);
    tick(1);
    checkOutput("toClear", 32'(fetchErr), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    tick(1);
    checkOutput("toResumeCs", 32'(romCs), 32'h1);
    checkOutput("toResumeAddr", 32'(romAddr), 32'h0010);
`else
    tick(20);
    checkOutput("stuckCs", 32'(romCs), 32'h1);
    checkOutput("stuckAddr", 32'(romAddr), 32'h0000);
    checkOutput("stuckErr", 32'(fetchErr), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
